// File: rtl/player_input_capture.sv
// Synchronised, debounced player-input peripheral with sticky edge flags and maskable IRQ on Avalon-MM.
// Latency: readdata 1 cycle after avs_read; no wait states, so no backpressure is ever applied.
module player_input_capture #(
    parameter int NUM_CH          = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] datac,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic              irq
);

    localparam int INIT_LEN = SYNC_STAGES + 1;
    localparam int INIT_W   = $clog2(INIT_LEN + 1);

    logic [NUM_CH-1:0] sync_ff [SYNC_STAGES];
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [NUM_CH-1:0] sync;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] stable_nxt;
    logic [NUM_CH-1:0] edge_flags;
    logic [NUM_CH-1:0] edge_set;
    logic [NUM_CH-1:0] edge_clr;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] mask;
    logic [1:0]        mode;
    logic              bypass;
    logic [INIT_W-1:0] init_cnt;
    logic              in_init;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign sync         = sync_ff[SYNC_STAGES-1];
    assign in_init      = (init_cnt != INIT_W'(INIT_LEN));
    assign unused_wdata = ^avs_writedata;

    // During init the stable state just follows the synchroniser so idle-high keys settle silently.
    always_comb begin
        stable_nxt = stable;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_init || bypass)
                stable_nxt[c] = sync[c];
            else if (sync[c] != stable[c] && cnt[c] == CNT_W'(DEBOUNCE_CYCLES - 1))
                stable_nxt[c] = sync[c];
        end
    end

    assign rise = stable_nxt & ~stable;
    assign fall = ~stable_nxt & stable;

    always_comb begin
        edge_set = '0;
        case (mode)
            2'b00:   edge_set = rise;
            2'b01:   edge_set = fall;
            2'b10:   edge_set = rise | fall;
            default: edge_set = '0;
        endcase
        if (in_init)
            edge_set = '0;
    end

    assign edge_clr = (avs_write && avs_address == 2'd1) ? avs_writedata[NUM_CH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: rd_mux[NUM_CH-1:0] = stable;
            2'd1: rd_mux[NUM_CH-1:0] = edge_flags;
            2'd2: rd_mux[NUM_CH-1:0] = mask;
            default: begin
                rd_mux[1:0] = mode;
                rd_mux[8]   = bypass;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_ff[i] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                cnt[c] <= '0;
            stable       <= '0;
            edge_flags   <= '0;
            mask         <= '0;
            mode         <= 2'b00;
            bypass       <= 1'b0;
            init_cnt     <= '0;
            avs_readdata <= '0;
        end else begin
            sync_ff[0] <= datac;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_ff[i] <= sync_ff[i-1];
            if (in_init)
                init_cnt <= init_cnt + INIT_W'(1);
            stable <= stable_nxt;
            // A matching sample restarts the window; acceptance also restarts it, so the counter never wraps.
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_init || bypass || sync[c] == stable[c])
                    cnt[c] <= '0;
                else if (cnt[c] == CNT_W'(DEBOUNCE_CYCLES - 1))
                    cnt[c] <= '0;
                else
                    cnt[c] <= cnt[c] + CNT_W'(1);
            end
            edge_flags <= (edge_flags & ~edge_clr) | edge_set;
            if (avs_write && avs_address == 2'd2)
                mask <= avs_writedata[NUM_CH-1:0];
            if (avs_write && avs_address == 2'd3) begin
                mode   <= avs_writedata[1:0];
                bypass <= avs_writedata[8];
            end
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

    assign irq = |(edge_flags & mask);

endmodule

// File: tb/tb_player_input_capture.sv
module tb_player_input_capture;
    localparam int N = 10;
    localparam int S = 2;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] datac;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_input_capture #(
        .NUM_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .datac(datac),
        .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
    );

    // Reference model: the debounced value flips once the last D synchronised samples all disagree with it.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_stable = '0, m_edge = '0, m_mask = '0, m_nxt, m_sel, m_sync;
    logic [1:0]   m_mode = 2'b00;
    logic         m_bypass = 1'b0;
    logic [31:0]  m_rd = '0;
    int           m_init = 0;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v[N-1:0] = m_stable;
            2'd1: v[N-1:0] = m_edge;
            2'd2: v[N-1:0] = m_mask;
            default: begin v[1:0] = m_mode; v[8] = m_bypass; end
        endcase
        return v;
    endfunction

    function automatic bit win_flip(input int c);
        if (hist.size() < S + D - 1) return 1'b0;
        for (int j = 0; j < D; j++)
            if (hist[hist.size() - S - j][c] == m_stable[c]) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            hist.delete();
            for (int i = 0; i < S; i++) hist.push_back('0);
            m_stable = '0; m_edge = '0; m_mask = '0; m_mode = 2'b00;
            m_bypass = 1'b0; m_rd = '0; m_init = 0;
        end else begin
            m_sync = hist[hist.size() - S];
            m_nxt  = m_stable;
            m_sel  = '0;
            if (m_init < S + 1) begin
                m_nxt = m_sync;
                m_init++;
            end else begin
                if (m_bypass) m_nxt = m_sync;
                else for (int c = 0; c < N; c++) if (win_flip(c)) m_nxt[c] = ~m_stable[c];
                if (m_mode == 2'b00 || m_mode == 2'b10) m_sel |= m_nxt & ~m_stable;
                if (m_mode == 2'b01 || m_mode == 2'b10) m_sel |= ~m_nxt & m_stable;
            end
            if (avs_read) m_rd = m_reg(avs_address);
            if (avs_write && avs_address == 2'd1) m_edge &= ~avs_writedata[N-1:0];
            m_edge |= m_sel;
            if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[N-1:0];
            if (avs_write && avs_address == 2'd3) begin
                m_mode   = avs_writedata[1:0];
                m_bypass = avs_writedata[8];
            end
            m_stable = m_nxt;
            hist.push_back(datac);
            if (hist.size() > S + D + 4) void'(hist.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1; datac = '1;
        avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) tick();
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset = 1'b0;
        repeat (20) tick();
        bus_read(2'd0, r);
        checks++; if (r !== 32'h3FF) begin errors++; $display("FAIL init_data got=%h exp=3ff", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL init_edge got=%h exp=0", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL init_irq got=%b exp=0", irq); end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] r;
        logic        exp;
        datac = '0;
        repeat (30) tick();
        bus_read(2'd1, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL fall_ignored_rise_mode got=%h exp=0", r); end
        datac[0] = 1'b1;
        avs_address = 2'd0; avs_read = 1'b1;
        for (int k = 1; k <= S + D + 4; k++) begin
            tick();
            exp = (k >= S + D + 1);
            checks++;
            if (avs_readdata[0] !== exp) begin
                errors++; $display("FAIL latency_data0 cycle=%0d got=%b exp=%b", k, avs_readdata[0], exp);
            end
        end
        avs_read = 1'b0;
        bus_read(2'd1, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL edge0_rise got=%h exp=1", r); end
    endtask

    task automatic test_glitch();
        logic [31:0] r;
        datac[3] = 1'b1;
        repeat (10) tick();
        datac[3] = 1'b0;
        repeat (30) tick();
        bus_read(2'd0, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL glitch_data got=%h exp=1", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL glitch_edge got=%h exp=1", r); end
    endtask

    task automatic test_boundary();
        logic [31:0] r;
        datac[4] = 1'b1;
        repeat (D - 1) tick();
        datac[4] = 1'b0;
        repeat (30) tick();
        bus_read(2'd0, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL short_by_one got=%h exp=1", r); end
        datac[4] = 1'b1;
        repeat (D) tick();
        datac[4] = 1'b0;
        repeat (S + 2) tick();
        bus_read(2'd0, r);
        checks++; if (r !== 32'h11) begin errors++; $display("FAIL exact_window got=%h exp=11", r); end
        repeat (40) tick();
        bus_read(2'd0, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL window_release got=%h exp=1", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 32'h11) begin errors++; $display("FAIL window_edge got=%h exp=11", r); end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h1);
        datac[0] = 1'b0;
        repeat (25) tick();
        datac[0] = 1'b1;
        repeat (25) tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
        bus_write(2'd1, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
        datac[1] = 1'b1;
        repeat (25) tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
        bus_read(2'd1, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL masked_edge got=%h exp=2", r); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] r;
        datac[2] = 1'b1;
        repeat (25) tick();
        datac[2] = 1'b0;
        repeat (25) tick();
        bus_read(2'd1, r);
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL pre_collision got=%h exp=6", r); end
        datac[2] = 1'b1;
        repeat (S + D - 1) tick();
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, r);
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL set_wins got=%h exp=6", r); end
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL w1c_plain got=%h exp=2", r); end
    endtask

    task automatic test_bypass();
        logic [31:0] r;
        logic        exp;
        bus_write(2'd3, 32'h102);
        datac[5] = 1'b1;
        repeat (5) tick();
        bus_write(2'd1, 32'hFFFF_FFFF);
        datac[5] = 1'b0;
        avs_address = 2'd0; avs_read = 1'b1;
        for (int k = 1; k <= S + 4; k++) begin
            tick();
            exp = (k < S + 2);
            checks++;
            if (avs_readdata[5] !== exp) begin
                errors++; $display("FAIL bypass_data5 cycle=%0d got=%b exp=%b", k, avs_readdata[5], exp);
            end
        end
        avs_read = 1'b0;
        bus_read(2'd1, r);
        checks++; if (r !== 32'h20) begin errors++; $display("FAIL bypass_fall_edge got=%h exp=20", r); end
        bus_read(2'd3, r);
        checks++; if (r !== 32'h102) begin errors++; $display("FAIL ctrl_read got=%h exp=102", r); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, r);
        checks++; if (r !== 32'h103) begin errors++; $display("FAIL ctrl_unused got=%h exp=103", r); end
        bus_write(2'd3, 32'h0);
    endtask

    task automatic test_simul_rw();
        logic [31:0] r;
        avs_address = 2'd2; avs_writedata = 32'h3FF; avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        checks++; if (avs_readdata !== 32'h1) begin errors++; $display("FAIL rw_pre_value got=%h exp=1", avs_readdata); end
        tick();
        checks++; if (avs_readdata !== 32'h1) begin errors++; $display("FAIL readdata_hold got=%h exp=1", avs_readdata); end
        bus_read(2'd2, r);
        checks++; if (r !== 32'h3FF) begin errors++; $display("FAIL mask_written got=%h exp=3ff", r); end
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, r);
        checks++; if (r !== 32'h7) begin errors++; $display("FAIL data_ro got=%h exp=7", r); end
    endtask

    task automatic test_random();
        int op;
        logic [31:0] wd;
        for (int i = 0; i < 3000; i++) begin
            avs_read = 1'b0; avs_write = 1'b0;
            if (i == 1500) reset = 1'b1;
            if (i == 1502) reset = 1'b0;
            if ($urandom_range(0, 11) == 0) datac[$urandom_range(0, N - 1)] ^= 1'b1;
            op = $urandom_range(0, 9);
            avs_address = 2'($urandom_range(0, 3));
            avs_writedata = $urandom;
            case (op)
                0, 1, 2, 3: avs_read = 1'b1;
                4: begin avs_write = 1'b1; avs_address = 2'd2; end
                5: begin avs_write = 1'b1; avs_address = 2'd1; end
                6: begin
                    wd = 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) wd[8] = 1'b1;
                    avs_write = 1'b1; avs_address = 2'd3; avs_writedata = wd;
                end
                7: begin avs_read = 1'b1; avs_write = 1'b1; end
                default: ;
            endcase
            tick();
            checks++;
            if (avs_readdata !== m_rd) begin
                errors++; $display("FAIL rand_readdata cycle=%0d got=%h exp=%h", i, avs_readdata, m_rd);
            end
            checks++;
            if (irq !== |(m_edge & m_mask)) begin
                errors++; $display("FAIL rand_irq cycle=%0d got=%b exp=%b", i, irq, |(m_edge & m_mask));
            end
        end
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_boundary();
        test_irq();
        test_w1c_collision();
        test_bypass();
        test_simul_rw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
